// File: rtl/uno_seq_if.sv
// Request/response handshake and coefficient/exp-scale ROM signals of the uno_seq PE.
// slave is the PE side; master is the array/controller side.
interface uno_seq_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned IDX_W  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                op;
    logic [DATA_W-1:0]         x;
    logic [DATA_W-1:0]         y;
    logic [2*DATA_W-1:0]       z;
    logic                      acc_en;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_W-1:0]       out_data;
    logic                      out_err;
    logic [1:0]                coef_op;
    logic [IDX_W-1:0]          coef_idx;
    logic [DATA_W-1:0]         coef_data;
    logic [DATA_W-FRAC_W-1:0]  exps_idx;
    logic [DATA_W-1:0]         exps_data;

    modport slave (
        input  in_valid, op, x, y, z, acc_en, out_ready, coef_data, exps_data,
        output in_ready, out_valid, out_data, out_err, coef_op, coef_idx, exps_idx
    );

    modport master (
        output in_valid, op, x, y, z, acc_en, out_ready, coef_data, exps_data,
        input  in_ready, out_valid, out_data, out_err, coef_op, coef_idx, exps_idx
    );
endinterface

// File: rtl/uno_seq.sv
// Self-sequencing nonlinear PE: MAC, DIV, EXP and LOG on one shared multiplier,
// with Horner polynomial evaluation driven by an internal term sequencer.
module uno_seq #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned FRAC_W  = 8,
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned LN2_Q   = 177
) (
    input  logic     clk,
    input  logic     rst_n,
    uno_seq_if.slave bus
);
    localparam int unsigned INT_W  = DATA_W - FRAC_W;
    localparam int unsigned WIDE_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = WIDE_W + 1;
    localparam int unsigned S_W    = $clog2(FRAC_W + 1);

    localparam logic [1:0] OP_MAC = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_EXP = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] Q_ONE = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] Q_3_4 = DATA_W'(3 << (FRAC_W - 2));

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_PREP, S_HORN, S_FINAL, S_DONE} state_t;

    state_t                    r_state;
    logic [1:0]                r_op;
    logic signed [DATA_W-1:0]  r_x, r_y, r_acc, r_v, r_scale;
    logic signed [WIDE_W-1:0]  r_z, r_offset, r_out_data;
    logic                      r_acc_en, r_err, r_out_err, r_out_valid, r_in_ready;
    logic [IDX_W-1:0]          r_coef_idx;

    function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [SUM_W-1:0] a);
        if (a > SUM_W'(Q_MAX)) return Q_MAX;
        if (a < SUM_W'(Q_MIN)) return Q_MIN;
        return DATA_W'(a);
    endfunction

    function automatic logic [S_W-1:0] f_lzc(input logic [FRAC_W-1:0] f);
        logic [S_W-1:0] n;
        n = S_W'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++) begin
            if (f[i]) n = S_W'(FRAC_W - 1 - i);
        end
        return n;
    endfunction

    logic [FRAC_W-1:0]         w_frac, w_xnorm;
    logic [INT_W-1:0]          w_int;
    logic [S_W-1:0]            w_s;
    logic signed [DATA_W-1:0]  w_v_norm, w_mul_a, w_mul_b, w_horn, w_final;
    logic signed [WIDE_W-1:0]  w_y_sh, w_prod, w_mac;
    logic [WIDE_W-1:0]         w_log_off;
    logic                      w_dom_err;

    // Range reduction: normalise the fraction into [0.5,1) and centre it on 0.75
    assign w_frac    = r_x[FRAC_W-1:0];
    assign w_int     = r_x[DATA_W-1:FRAC_W];
    assign w_s       = f_lzc(w_frac);
    assign w_xnorm   = w_frac << w_s;
    assign w_v_norm  = Q_3_4 - $signed(DATA_W'(w_xnorm));
    assign w_y_sh    = WIDE_W'(r_y) <<< w_s;
    assign w_log_off = WIDE_W'(0) - WIDE_W'(w_s) * WIDE_W'(LN2_Q);
    assign w_dom_err = r_op[0] && ((w_frac == '0) || (w_int != '0));

    // Single multiplier shared by MAC, Horner steps and final scaling
    always_comb begin
        w_mul_a = r_x;
        w_mul_b = r_y;
        case (r_state)
            S_HORN:  begin w_mul_a = r_acc; w_mul_b = r_v;     end
            S_FINAL: begin w_mul_a = r_acc; w_mul_b = r_scale; end
            default: ;
        endcase
    end

    assign w_prod  = w_mul_a * w_mul_b;
    assign w_mac   = w_prod + (r_acc_en ? r_out_data : r_z);
    assign w_horn  = f_sat(SUM_W'(w_prod >>> FRAC_W) + SUM_W'($signed(bus.coef_data)));
    assign w_final = f_sat(SUM_W'(w_prod >>> FRAC_W) + SUM_W'(r_offset));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_acc_en    <= 1'b0;
            r_acc       <= '0;
            r_v         <= '0;
            r_scale     <= '0;
            r_offset    <= '0;
            r_err       <= 1'b0;
            r_coef_idx  <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.op;
                        r_x        <= bus.x;
                        r_y        <= bus.y;
                        r_z        <= bus.z;
                        r_acc_en   <= bus.acc_en;
                        r_in_ready <= 1'b0;
                        r_coef_idx <= IDX_W'(N_TERMS - 1);
                        r_state    <= (bus.op == OP_MAC) ? S_MAC : S_PREP;
                    end
                end
                S_MAC: begin
                    r_out_data  <= w_mac;
                    r_out_err   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_coef_idx  <= '0;
                    r_state     <= S_DONE;
                end
                S_PREP: begin
                    r_acc      <= $signed(bus.coef_data);
                    r_coef_idx <= IDX_W'(N_TERMS - 2);
                    r_err      <= w_dom_err;
                    r_offset   <= '0;
                    r_v        <= w_v_norm;
                    case (r_op)
                        OP_DIV:  r_scale <= f_sat(SUM_W'(w_y_sh));
                        OP_LOG:  begin
                            r_scale  <= Q_ONE;
                            r_offset <= $signed(w_log_off);
                        end
                        OP_EXP:  begin
                            r_scale <= $signed(bus.exps_data);
                            r_v     <= $signed(DATA_W'(w_frac));
                        end
                        default: r_scale <= Q_ONE;
                    endcase
                    r_state <= S_HORN;
                end
                S_HORN: begin
                    r_acc <= w_horn;
                    if (r_coef_idx == '0) r_state <= S_FINAL;
                    else                  r_coef_idx <= r_coef_idx - IDX_W'(1);
                end
                S_FINAL: begin
                    if (r_err) r_out_data <= (r_op == OP_DIV) ? WIDE_W'(Q_MAX) : WIDE_W'(Q_MIN);
                    else       r_out_data <= WIDE_W'(w_final);
                    r_out_err   <= r_err;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;
    assign bus.coef_op   = r_op;
    assign bus.coef_idx  = r_coef_idx;
    assign bus.exps_idx  = r_x[DATA_W-1:FRAC_W];
endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq: MAC chain, DIV/LOG/EXP datapath, domain errors,
// output backpressure and asynchronous reset in the middle of a Horner run.
module tb_uno_seq;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned N_TERMS = 4;
    localparam int unsigned IDX_W   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DATA_W-1:0]        coef_tbl [N_TERMS];
    logic [DATA_W-1:0]        exps_val;
    logic [IDX_W-1:0]         g_idx0;
    logic [1:0]               g_op0;
    logic [DATA_W-FRAC_W-1:0] g_exps0;

    uno_seq_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .IDX_W(IDX_W)) bus ();

    uno_seq #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_TERMS(N_TERMS), .IDX_W(IDX_W), .LN2_Q(177)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.coef_data = coef_tbl[bus.coef_idx];
    assign bus.exps_data = exps_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_coefs(input logic [11:0] c0, input logic [11:0] c1,
                             input logic [11:0] c2, input logic [11:0] c3);
        coef_tbl[0] = c0;
        coef_tbl[1] = c1;
        coef_tbl[2] = c2;
        coef_tbl[3] = c3;
    endtask

    // Issue one request, scramble inputs after accept, wait (bounded) for out_valid
    task automatic run_req(input string tag, input logic [1:0] op, input logic [11:0] x,
                           input logic [11:0] y, input logic [23:0] z, input logic acc_en,
                           input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op       = op;
        bus.x        = x;
        bus.y        = y;
        bus.z        = z;
        bus.acc_en   = acc_en;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        g_idx0       = bus.coef_idx;
        g_op0        = bus.coef_op;
        g_exps0      = bus.exps_idx;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.x        = 12'($urandom);
        bus.y        = 12'($urandom);
        bus.z        = 24'($urandom);
        bus.acc_en   = ~acc_en;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Check a presented result, then let the out_ready=1 handshake complete
    task automatic expect_result(input string tag, input logic [23:0] data, input logic err);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"},  32'(bus.out_data),  32'(data));
        check({tag, "_err"},   32'(bus.out_err),   32'(err));
        check({tag, "_busy"},  32'(bus.in_ready),  32'd0);
        @(posedge clk);
        #1;
        check({tag, "_after_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_after_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.x         = '0;
        bus.y         = '0;
        bus.z         = '0;
        bus.acc_en    = 1'b0;
        bus.out_ready = 1'b1;
        exps_val      = '0;
        set_coefs(12'd0, 12'd0, 12'd0, 12'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_coef_idx",  32'(bus.coef_idx),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // MAC and accumulate chain
        run_req("mac1", 2'b00, 12'd3, 12'd5, 24'd7, 1'b0, 1);
        expect_result("mac1", 24'd22, 1'b0);
        run_req("mac2", 2'b00, 12'd2, 12'd2, 24'd0, 1'b1, 1);
        expect_result("mac2", 24'd26, 1'b0);

        // DIV: s=1, v=0x40, scale=0x200
        set_coefs(12'd0, 12'd256, 12'd0, 12'd0);
        run_req("div1", 2'b01, 12'h040, 12'h100, 24'd0, 1'b0, 5);
        check("div1_first_coef_idx", 32'(g_idx0), 32'd3);
        check("div1_coef_op",        32'(g_op0),  32'd1);
        expect_result("div1", 24'h000080, 1'b0);
        set_coefs(12'd256, 12'd0, 12'd0, 12'd0);
        run_req("div2", 2'b01, 12'h040, 12'h100, 24'd0, 1'b0, 5);
        expect_result("div2", 24'h000200, 1'b0);

        // DIV domain error: nonzero integer part forces max positive
        run_req("div_err", 2'b01, 12'h140, 12'h100, 24'd0, 1'b0, 5);
        expect_result("div_err", 24'h0007FF, 1'b1);

        // LOG: -2*177 = -354; zero operand forces min negative
        set_coefs(12'd0, 12'd0, 12'd0, 12'd0);
        run_req("log1", 2'b11, 12'h020, 12'h000, 24'd0, 1'b0, 5);
        expect_result("log1", 24'hFFFE9E, 1'b0);
        run_req("log_err", 2'b11, 12'h000, 12'h000, 24'd0, 1'b0, 5);
        expect_result("log_err", 24'hFFF800, 1'b1);

        // EXP: integer part selects exp scale, c0=1.0 passes it through
        exps_val = 12'd696;
        set_coefs(12'd256, 12'd0, 12'd0, 12'd0);
        run_req("exp1", 2'b10, 12'h1C0, 12'h000, 24'd0, 1'b0, 5);
        check("exp1_exps_idx", 32'(g_exps0), 32'd1);
        check("exp1_coef_op",  32'(g_op0),   32'd2);
        expect_result("exp1", 24'd696, 1'b0);

        // Backpressure: result and busy state held while out_ready is low
        set_coefs(12'd256, 12'd0, 12'd0, 12'd0);
        bus.out_ready = 1'b0;
        run_req("bp", 2'b01, 12'h040, 12'h100, 24'd0, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data",  32'(bus.out_data),  32'h200);
            check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        check("bp_handshake_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        check("bp_keep_data",     32'(bus.out_data),  32'h200);

        // Reset during the second Horner cycle
        set_coefs(12'd0, 12'd256, 12'd0, 12'd0);
        @(negedge clk);
        bus.op       = 2'b01;
        bus.x        = 12'h040;
        bus.y        = 12'h100;
        bus.acc_en   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_horn_idx", 32'(bus.coef_idx), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",    32'(bus.out_valid), 32'd0);
        check("rst_mid_data",     32'(bus.out_data),  32'd0);
        check("rst_mid_coef_idx", 32'(bus.coef_idx),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_post_valid", 32'(bus.out_valid), 32'd0);
        check("rst_post_ready", 32'(bus.in_ready),  32'd1);

        // Accumulator chain restarts from the cleared result
        run_req("mac_post", 2'b00, 12'd2, 12'd3, 24'd100, 1'b1, 1);
        expect_result("mac_post", 24'd6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
